systolic_mm_array: RTL and testbench
====================================

Name: systolic_mm_array

Overview:
Parametrised N x N output-stationary systolic matrix-multiply engine. It is the successor to the fixed 4x4 byte array and adds:
- built-in input skew
- a start/busy/done sequencer
- arbitrary inner dimension K
- ready/valid streaming in and out
- row-serial result drain

Operands arrive one K-beat per cycle: lane i of a_vec = A[i][k], lane j of b_vec = B[k][j]. It computes C = A x B.

Parameters:
- N, 4, array rows = columns = lanes per vector.
- DATA_W, 8, operand width.
- ACC_W, 32, accumulator width; must be >= 2*DATA_W (elaboration error otherwise).
- KLEN_W, 8, width of k_len.
- RW, max(1,$clog2(N)), width of out_row (derived, not overridable).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin job; sampled only in IDLE.
- k_len  in  KLEN_W  number of K beats, latched on accepted start.
- in_valid  in  1  a_vec/b_vec beat valid.
- in_ready  out  1  beat accepted when in_valid & in_ready.
- a_vec  in  N*DATA_W  lane i at [i*DATA_W +: DATA_W].
- b_vec  in  N*DATA_W  lane j at [j*DATA_W +: DATA_W].
- out_valid  out  1  result row valid.
- out_ready  in  1  consumer accepts row.
- out_row  out  RW  index of presented row.
- out_data  out  N*ACC_W  C[out_row][j] at [j*ACC_W +: ACC_W].
- busy  out  1  high in any state but IDLE.
- done  out  1  one-cycle pulse after final row handshake.

Behaviour:
- Reset (rst=1 at edge, any state): FSM to IDLE; all accumulators, skew and pass-through registers cleared. Outputs: in_ready 0, out_valid 0, out_row 0, out_data 0, busy 0, done 0. Reset mid-job aborts the job with no residue.
- FSM states: IDLE, LOAD, FLUSH, DRAIN.
- IDLE:
  - On start=1, latch k_len and clear all accumulators.
  - If k_len!=0, go to LOAD; if k_len==0, go to DRAIN (all results 0).
  - start in any other state is ignored.
- LOAD:
  - in_ready=1. Each accepted beat increments the beat counter.
  - Row-i A lane passes through i skew registers; column-j B lane passes through j skew registers.
  - Cycles with in_valid=0 inject zeros into the skew inputs (bubbles are harmless).
  - On acceptance of beat k_len-1, go to FLUSH.
- FLUSH: in_ready=0; zeros injected; lasts exactly 2N-1 cycles, then DRAIN.
- PE(i,j):
  - Each cycle: acc <= acc + a_in*b_in.
  - Registers a_in to the right and b_in downward (1-cycle hop).
  - Beat k reaches PE(i,j) i+j cycles after acceptance; every PE sees matching k pairs only.
- Arithmetic:
  - Product is 2*DATA_W wide, extended to ACC_W.
  - Accumulation wraps modulo 2^ACC_W; no saturation, no overflow flag.
- Latency: if the last beat is accepted in cycle T, out_valid first asserts in cycle T+2N (N=4: T+8). With k_len=0, out_valid asserts the cycle after start.
- DRAIN:
  - out_valid=1; out_row=r, starting at 0; out_data = row r accumulators.
  - On out_valid & out_ready, r increments. out_row and out_data are held stable while out_ready=0.
  - After the handshake of row N-1: go to IDLE, out_valid drops next cycle, done=1 for exactly that one cycle, busy=0.
- Accumulators are not modified during DRAIN. They retain values in IDLE until the next accepted start.

Optional Feature:
SYSTOLIC_SIGNED_EN
- Defined: operands are two's complement; product is signed, sign-extended to ACC_W.
- Undefined: operands are unsigned; product is zero-extended.
- Timing and interface are identical in both builds.

Test Plan:
1. Identity, N=4, DATA_W=8:
   - Stimulus: A=I, B[k][j]=4k+j+1, k_len=4, contiguous beats.
   - Required: rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16}; out_valid first at T+8; done pulses once.
2. Bubbles:
   - Stimulus: k_len=3, all A=2, all B=3, in_valid low 2 cycles between each beat.
   - Required: every C element = 18; in_ready low outside LOAD.
3. Backpressure:
   - Stimulus: hold out_ready=0 for 3 cycles while out_row=1.
   - Required: out_row=1 and out_data unchanged throughout; done only after row 3 handshake; busy high until then.
4. Empty and ignored start:
   - Stimulus: k_len=0.
   - Required: DRAIN the next cycle, four zero rows, done.
   - Also: start pulsed during LOAD/DRAIN has no effect on the result.
5. Wrap/sign, ACC_W=16:
   - Stimulus: all operands 8'hFF, k_len=255.
   - Required: unsigned build gives every element 767 (16581375 mod 65536); SYSTOLIC_SIGNED_EN build gives 255.
6. Reset mid-LOAD:
   - Stimulus: assert rst after 2 accepted beats.
   - Required: all outputs at reset values next cycle.
   - Follow-up: new start, k_len=1, A=1, B=5 gives all elements 5 (no residue).

Source files
------------

// File: rtl/systolic_mm_array.sv
// systolic_mm_array: N x N output-stationary systolic matrix multiplier.
// Streams one K-beat of A columns / B rows per accepted cycle, skews them
// into the array, flushes the wavefront, then drains C one row at a time.
// Optional build macro: SYSTOLIC_SIGNED_EN (two's-complement operands).
module systolic_mm_array #(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int KLEN_W = 8,
    localparam int RW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [KLEN_W-1:0]     k_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N*DATA_W-1:0]   a_vec,
    input  logic [N*DATA_W-1:0]   b_vec,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [RW-1:0]         out_row,
    output logic [N*ACC_W-1:0]    out_data,
    output logic                  busy,
    output logic                  done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    // Flush counter must reach 2N-2 (2N-1 flush cycles).
    localparam int FW = $clog2(2 * N);

    if (ACC_W < 2 * DATA_W) begin : g_bad_acc_w
        $error("systolic_mm_array: ACC_W must be >= 2*DATA_W");
    end

    logic [1:0]        r_state;
    logic [KLEN_W-1:0] r_k_len;
    logic [KLEN_W-1:0] r_beat_cnt;
    logic [FW-1:0]     r_flush_cnt;
    logic [RW-1:0]     r_row;
    logic              r_done;

    logic w_in_fire;
    logic w_acc_clr;
    logic w_acc_en;

    // Operand lanes entering the array edges and travelling through it.
    logic [DATA_W-1:0] w_a_lane [N];
    logic [DATA_W-1:0] w_b_lane [N];
    logic [DATA_W-1:0] w_a_in   [N][N];
    logic [DATA_W-1:0] w_b_in   [N][N];
    logic [ACC_W-1:0]  w_acc    [N][N];

    assign in_ready  = (r_state == S_LOAD);
    assign out_valid = (r_state == S_DRAIN);
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign out_row   = r_row;

    assign w_in_fire = in_valid && (r_state == S_LOAD);
    assign w_acc_clr = start && (r_state == S_IDLE);
    // Accumulators only move while data can be in flight; frozen in DRAIN/IDLE.
    assign w_acc_en  = (r_state == S_LOAD) || (r_state == S_FLUSH);

    // Job sequencer: IDLE -> LOAD -> FLUSH -> DRAIN -> IDLE, with done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_k_len     <= '0;
            r_beat_cnt  <= '0;
            r_flush_cnt <= '0;
            r_row       <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_k_len    <= k_len;
                        r_beat_cnt <= '0;
                        r_row      <= '0;
                        r_state    <= (k_len == '0) ? S_DRAIN : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_in_fire) begin
                        r_beat_cnt <= r_beat_cnt + KLEN_W'(1);
                        if ((r_beat_cnt + KLEN_W'(1)) == r_k_len) begin
                            r_flush_cnt <= '0;
                            r_state     <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    if (r_flush_cnt == FW'(2 * N - 2)) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_flush_cnt <= r_flush_cnt + FW'(1);
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        if (r_row == RW'(N - 1)) begin
                            r_row   <= '0;
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_row <= r_row + RW'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Input skew: lane gi is delayed by gi cycles so beat k meets its
    // partner at PE(i,j) exactly i+j cycles after acceptance.
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        assign w_a_lane[gi] = w_in_fire ? a_vec[gi*DATA_W +: DATA_W] : '0;
        assign w_b_lane[gi] = w_in_fire ? b_vec[gi*DATA_W +: DATA_W] : '0;

        if (gi == 0) begin : g_no_skew
            assign w_a_in[0][0] = w_a_lane[0];
            assign w_b_in[0][0] = w_b_lane[0];
        end else begin : g_skew
            logic [DATA_W-1:0] r_a_skew [gi];
            logic [DATA_W-1:0] r_b_skew [gi];

            // Shift chain of gi stages per lane; idle cycles push zeros.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int s = 0; s < gi; s++) begin
                        r_a_skew[s] <= '0;
                        r_b_skew[s] <= '0;
                    end
                end else begin
                    r_a_skew[0] <= w_a_lane[gi];
                    r_b_skew[0] <= w_b_lane[gi];
                    for (int s = 1; s < gi; s++) begin
                        r_a_skew[s] <= r_a_skew[s-1];
                        r_b_skew[s] <= r_b_skew[s-1];
                    end
                end
            end

            assign w_a_in[gi][0] = r_a_skew[gi-1];
            assign w_b_in[0][gi] = r_b_skew[gi-1];
        end
    end

    // Processing elements.
    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_pe
            logic [ACC_W-1:0]    r_acc;
            logic [2*DATA_W-1:0] w_a_x;
            logic [2*DATA_W-1:0] w_b_x;
            logic [2*DATA_W-1:0] w_prod;
            logic [ACC_W-1:0]    w_prod_ext;

`ifdef SYSTOLIC_SIGNED_EN
            // Sign-extend operands; the low 2*DATA_W product bits are the signed product.
            assign w_a_x      = {{DATA_W{w_a_in[gi][gj][DATA_W-1]}}, w_a_in[gi][gj]};
            assign w_b_x      = {{DATA_W{w_b_in[gi][gj][DATA_W-1]}}, w_b_in[gi][gj]};
            assign w_prod     = w_a_x * w_b_x;
            assign w_prod_ext = ACC_W'($signed(w_prod));
`else
            assign w_a_x      = {{DATA_W{1'b0}}, w_a_in[gi][gj]};
            assign w_b_x      = {{DATA_W{1'b0}}, w_b_in[gi][gj]};
            assign w_prod     = w_a_x * w_b_x;
            assign w_prod_ext = ACC_W'(w_prod);
`endif

            // Multiply-accumulate, wrapping modulo 2^ACC_W.
            always_ff @(posedge clk) begin
                if (rst || w_acc_clr) begin
                    r_acc <= '0;
                end else if (w_acc_en) begin
                    r_acc <= r_acc + w_prod_ext;
                end
            end

            assign w_acc[gi][gj] = r_acc;

            if (gj < N - 1) begin : g_a_hop
                logic [DATA_W-1:0] r_a_hop;
                // Forward A operand one PE to the right.
                always_ff @(posedge clk) begin
                    if (rst) r_a_hop <= '0;
                    else     r_a_hop <= w_a_in[gi][gj];
                end
                assign w_a_in[gi][gj+1] = r_a_hop;
            end

            if (gi < N - 1) begin : g_b_hop
                logic [DATA_W-1:0] r_b_hop;
                // Forward B operand one PE downward.
                always_ff @(posedge clk) begin
                    if (rst) r_b_hop <= '0;
                    else     r_b_hop <= w_b_in[gi][gj];
                end
                assign w_b_in[gi+1][gj] = r_b_hop;
            end
        end
    end

    // Present the accumulators of the currently selected row.
    for (genvar gj = 0; gj < N; gj++) begin : g_out
        assign out_data[gj*ACC_W +: ACC_W] = w_acc[r_row][gj];
    end

endmodule

// File: tb/tb_systolic_mm_array.sv
// Self-checking bench for systolic_mm_array (N=4, DATA_W=8, ACC_W=16).
module tb_systolic_mm_array;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 16;
    localparam int KW = 8;
    localparam int RW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [KW-1:0]   k_len = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [N*DW-1:0] a_vec = '0;
    logic [N*DW-1:0] b_vec = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [RW-1:0]   out_row;
    logic [N*AW-1:0] out_data;
    logic            busy;
    logic            done;

    systolic_mm_array #(.N(N), .DATA_W(DW), .ACC_W(AW), .KLEN_W(KW)) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready), .a_vec(a_vec), .b_vec(b_vec),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .out_data(out_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int done_cnt = 0;
    always @(negedge clk) if (done === 1'b1) done_cnt++;

    int n_checks = 0;
    int n_fail   = 0;

    logic [AW-1:0] got       [N][N];
    logic [RW-1:0] got_row   [N];
    logic          got_valid [N];

    task automatic start_job(input logic [KW-1:0] k);
        start = 1'b1;
        k_len = k;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [N*DW-1:0] a, input logic [N*DW-1:0] b, output int t);
        in_valid = 1'b1;
        a_vec    = a;
        b_vec    = b;
        t        = cyc;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Waits for DRAIN and captures all rows; optional stall and start pokes.
    task automatic collect(input int stall_row, input int stall_n, input bit poke_start,
                           output bit ok, output int first, output bit stable,
                           output bit done_after, output bit valid_after, output bit busy_after);
        logic [RW-1:0]   hold_row;
        logic [N*AW-1:0] hold_data;
        ok = 1'b0; first = -1; stable = 1'b1;
        done_after = 1'b0; valid_after = 1'b1; busy_after = 1'b1;
        for (int w = 0; w < 100 && out_valid !== 1'b1; w++) @(negedge clk);
        if (out_valid !== 1'b1) return;
        first = cyc;
        for (int r = 0; r < N; r++) begin
            if (poke_start) begin
                start = (r < N - 1);
                k_len = 8'd0;
            end
            got_row[r]   = out_row;
            got_valid[r] = out_valid;
            for (int j = 0; j < N; j++) got[r][j] = out_data[j*AW +: AW];
            if (r == stall_row) begin
                hold_row  = out_row;
                hold_data = out_data;
                out_ready = 1'b0;
                repeat (stall_n) begin
                    @(negedge clk);
                    if (out_row !== hold_row || out_data !== hold_data ||
                        busy !== 1'b1 || done !== 1'b0 || out_valid !== 1'b1) stable = 1'b0;
                end
                out_ready = 1'b1;
            end
            @(negedge clk);
        end
        start = 1'b0;
        done_after  = done;
        valid_after = out_valid;
        busy_after  = busy;
        ok = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset in_ready: got %b expected 0", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_row !== '0) begin n_fail++; $display("FAIL reset out_row: got %0d expected 0", out_row); end
        n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset out_data: got %h expected 0", out_data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b expected 0", done); end
        rst = 1'b0;
        @(negedge clk);
        $display("test_reset: outputs checked after reset");
    endtask

    task automatic test_identity();
        logic [N*DW-1:0] a, b;
        int t, t_last, first, d0;
        bit ok, stable, d_after, v_after, b_after;
        d0 = done_cnt;
        start_job(8'd4);
        for (int k = 0; k < N; k++) begin
            a = '0; b = '0;
            a[k*DW +: DW] = 8'd1;
            for (int j = 0; j < N; j++) b[j*DW +: DW] = DW'(4 * k + j + 1);
            send_beat(a, b, t);
            t_last = t;
        end
        collect(-1, 0, 1'b0, ok, first, stable, d_after, v_after, b_after);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL identity drain: out_valid never rose"); end
        n_checks++; if (first !== t_last + 8) begin n_fail++; $display("FAIL identity latency: got cycle %0d expected %0d", first, t_last + 8); end
        for (int r = 0; r < N; r++) begin
            n_checks++; if (got_row[r] !== RW'(r) || got_valid[r] !== 1'b1) begin n_fail++; $display("FAIL identity row index: got %0d expected %0d", got_row[r], r); end
            for (int j = 0; j < N; j++) begin
                n_checks++; if (got[r][j] !== AW'(4 * r + j + 1)) begin n_fail++; $display("FAIL identity C[%0d][%0d]: got %0d expected %0d", r, j, got[r][j], 4 * r + j + 1); end
            end
        end
        n_checks++; if (d_after !== 1'b1 || v_after !== 1'b0 || b_after !== 1'b0) begin n_fail++; $display("FAIL identity end: done/valid/busy got %b%b%b expected 100", d_after, v_after, b_after); end
        @(negedge clk);
        n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL identity done pulses: got %0d expected 1", done_cnt - d0); end
        $display("test_identity: latency %0d cycles, rows captured", first - t_last);
    endtask

    task automatic test_bubbles();
        logic [N*DW-1:0] a, b;
        int t, first;
        bit ok, stable, d_after, v_after, b_after;
        for (int j = 0; j < N; j++) begin a[j*DW +: DW] = 8'd2; b[j*DW +: DW] = 8'd3; end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bubbles idle in_ready: got %b expected 0", in_ready); end
        start_job(8'd3);
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bubbles load in_ready: got %b expected 1", in_ready); end
            send_beat(a, b, t);
            if (k < 2) repeat (2) @(negedge clk);
        end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bubbles flush in_ready: got %b expected 0", in_ready); end
        collect(-1, 0, 1'b0, ok, first, stable, d_after, v_after, b_after);
        n_checks++; if (!ok || first !== t + 8) begin n_fail++; $display("FAIL bubbles latency: got cycle %0d expected %0d", first, t + 8); end
        for (int r = 0; r < N; r++)
            for (int j = 0; j < N; j++) begin
                n_checks++; if (got[r][j] !== AW'(18)) begin n_fail++; $display("FAIL bubbles C[%0d][%0d]: got %0d expected 18", r, j, got[r][j]); end
            end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bubbles post in_ready: got %b expected 0", in_ready); end
        $display("test_bubbles: k_len=3 with 2-cycle gaps drained");
    endtask

    task automatic test_backpressure();
        logic [N*DW-1:0] a, b;
        int t, first, d0;
        bit ok, stable, d_after, v_after, b_after;
        for (int j = 0; j < N; j++) begin a[j*DW +: DW] = 8'd1; b[j*DW +: DW] = DW'(j + 1); end
        d0 = done_cnt;
        start_job(8'd2);
        send_beat(a, b, t);
        send_beat(a, b, t);
        collect(1, 3, 1'b0, ok, first, stable, d_after, v_after, b_after);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL backpressure drain: out_valid never rose"); end
        n_checks++; if (stable !== 1'b1) begin n_fail++; $display("FAIL backpressure hold: got stable=%b expected 1", stable); end
        for (int r = 0; r < N; r++)
            for (int j = 0; j < N; j++) begin
                n_checks++; if (got[r][j] !== AW'(2 * (j + 1))) begin n_fail++; $display("FAIL backpressure C[%0d][%0d]: got %0d expected %0d", r, j, got[r][j], 2 * (j + 1)); end
            end
        n_checks++; if (d_after !== 1'b1 || b_after !== 1'b0) begin n_fail++; $display("FAIL backpressure end: done/busy got %b%b expected 10", d_after, b_after); end
        n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL backpressure done pulses: got %0d expected 1", done_cnt - d0); end
        $display("test_backpressure: row 1 held for 3 cycles");
    endtask

    task automatic test_empty();
        int first, d0;
        bit ok, stable, d_after, v_after, b_after;
        d0 = done_cnt;
        start_job(8'd0);
        n_checks++; if (out_valid !== 1'b1 || busy !== 1'b1 || out_row !== '0) begin n_fail++; $display("FAIL empty drain entry: valid/busy/row got %b%b%0d expected 110", out_valid, busy, out_row); end
        collect(-1, 0, 1'b0, ok, first, stable, d_after, v_after, b_after);
        for (int r = 0; r < N; r++)
            for (int j = 0; j < N; j++) begin
                n_checks++; if (got[r][j] !== '0) begin n_fail++; $display("FAIL empty C[%0d][%0d]: got %0d expected 0", r, j, got[r][j]); end
            end
        n_checks++; if (d_after !== 1'b1 || done_cnt - d0 !== 1) begin n_fail++; $display("FAIL empty done: got %b count %0d expected 1 count 1", d_after, done_cnt - d0); end
        $display("test_empty: k_len=0 drained four zero rows");
    endtask

    task automatic test_ignored_start();
        logic [N*DW-1:0] a, b;
        int t, first;
        bit ok, stable, d_after, v_after, b_after;
        for (int j = 0; j < N; j++) begin a[j*DW +: DW] = 8'd1; b[j*DW +: DW] = DW'(j + 1); end
        start_job(8'd2);
        send_beat(a, b, t);
        start = 1'b1; k_len = 8'd7;
        @(negedge clk);
        start = 1'b0;
        send_beat(a, b, t);
        collect(-1, 0, 1'b1, ok, first, stable, d_after, v_after, b_after);
        n_checks++; if (!ok || first !== t + 8) begin n_fail++; $display("FAIL ignored_start latency: got cycle %0d expected %0d", first, t + 8); end
        for (int r = 0; r < N; r++)
            for (int j = 0; j < N; j++) begin
                n_checks++; if (got[r][j] !== AW'(2 * (j + 1))) begin n_fail++; $display("FAIL ignored_start C[%0d][%0d]: got %0d expected %0d", r, j, got[r][j], 2 * (j + 1)); end
            end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignored_start idle: busy got %b expected 0", busy); end
        $display("test_ignored_start: start pulses in LOAD/DRAIN had no effect");
    endtask

    task automatic test_wrap();
        logic [N*DW-1:0] a;
        logic [AW-1:0]   expv;
        int t, first;
        bit ok, stable, d_after, v_after, b_after;
`ifdef SYSTOLIC_SIGNED_EN
        expv = 16'd255;
`else
        expv = 16'd767;
`endif
        a = '1;
        start_job(8'd255);
        for (int k = 0; k < 255; k++) send_beat(a, a, t);
        collect(-1, 0, 1'b0, ok, first, stable, d_after, v_after, b_after);
        n_checks++; if (!ok || first !== t + 8) begin n_fail++; $display("FAIL wrap latency: got cycle %0d expected %0d", first, t + 8); end
        for (int r = 0; r < N; r++)
            for (int j = 0; j < N; j++) begin
                n_checks++; if (got[r][j] !== expv) begin n_fail++; $display("FAIL wrap C[%0d][%0d]: got %0d expected %0d", r, j, got[r][j], expv); end
            end
        $display("test_wrap: 255 beats of 0xFF accumulated, expected %0d", expv);
    endtask

    task automatic test_reset_mid_load();
        logic [N*DW-1:0] a, b;
        int t, first;
        bit ok, stable, d_after, v_after, b_after;
        for (int j = 0; j < N; j++) begin a[j*DW +: DW] = 8'd7; b[j*DW +: DW] = 8'd9; end
        start_job(8'd4);
        send_beat(a, b, t);
        send_beat(a, b, t);
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midreset flags: ready/valid/busy/done got %b%b%b%b expected 0000", in_ready, out_valid, busy, done); end
        n_checks++; if (out_row !== '0 || out_data !== '0) begin n_fail++; $display("FAIL midreset data: row %0d data %h expected 0 and 0", out_row, out_data); end
        rst = 1'b0;
        for (int j = 0; j < N; j++) begin a[j*DW +: DW] = 8'd1; b[j*DW +: DW] = 8'd5; end
        start_job(8'd1);
        send_beat(a, b, t);
        collect(-1, 0, 1'b0, ok, first, stable, d_after, v_after, b_after);
        n_checks++; if (!ok || first !== t + 8) begin n_fail++; $display("FAIL midreset latency: got cycle %0d expected %0d", first, t + 8); end
        for (int r = 0; r < N; r++)
            for (int j = 0; j < N; j++) begin
                n_checks++; if (got[r][j] !== AW'(5)) begin n_fail++; $display("FAIL midreset C[%0d][%0d]: got %0d expected 5", r, j, got[r][j]); end
            end
        $display("test_reset_mid_load: follow-up job gave all 5");
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_identity();
        test_bubbles();
        test_backpressure();
        test_empty();
        test_ignored_start();
        test_wrap();
        test_reset_mid_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
